// File: rtl/logic_arb_pkg.sv
// Shared types and helpers for logic_op_arbiter.
// Optional build macro LOGIC_OP_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
package logic_arb_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StExec = EXEC,
    StResp = RESP
  } state_e;

  // ID width for n requesters; never narrower than one bit.
  function automatic int unsigned calc_idw(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/logic_op_arbiter_if.sv
// Requester/result bus of logic_op_arbiter; master = client side, slave = arbiter side.
interface logic_op_arbiter_if
  import logic_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned IDW   = calc_idw(N_REQ)
);

  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] a_in;
  logic [N_REQ*DW-1:0] b_in;
  logic [N_REQ-1:0]    gnt;
  logic                res_vld;
  logic [IDW-1:0]      res_id;
  logic [DW-1:0]       res_data;
  logic                busy;

  modport master (
    output req,
    output a_in,
    output b_in,
    input  gnt,
    input  res_vld,
    input  res_id,
    input  res_data,
    input  busy
  );

  modport slave (
    input  req,
    input  a_in,
    input  b_in,
    output gnt,
    output res_vld,
    output res_id,
    output res_data,
    output busy
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational winner selection: round-robin wrap search from ptr_i, or a plain
// lowest-index priority encoder when LOGIC_OP_ARB_FIXED_PRIO_EN is defined.
module rr_pick
  import logic_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDW   = calc_idw(N_REQ)
) (
`ifndef LOGIC_OP_ARB_FIXED_PRIO_EN
  input  logic [IDW-1:0]   ptr_i,
`endif
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDW-1:0]   idx_o
);

  function automatic logic [N_REQ-1:0] first_one(input logic [N_REQ-1:0] v);
    logic [N_REQ-1:0] oh;
    logic             seen;
    oh   = '0;
    seen = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (v[i] && !seen) begin
        oh[i] = 1'b1;
        seen  = 1'b1;
      end
    end
    return oh;
  endfunction

`ifndef LOGIC_OP_ARB_FIXED_PRIO_EN
  logic [N_REQ-1:0] upper_mask;
  logic [N_REQ-1:0] req_upper;

  // Requests at or above ptr win first; otherwise wrap to the lowest index.
  always_comb begin
    upper_mask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      upper_mask[i] = (i >= int'(ptr_i));
    end
    req_upper = req_i & upper_mask;
    gnt_o     = (|req_upper) ? first_one(req_upper) : first_one(req_i);
  end
`else
  always_comb begin
    gnt_o = first_one(req_i);
  end
`endif

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_o[i]) idx_o = IDW'(i);
    end
  end

endmodule

// File: rtl/logic_op_arbiter.sv
// Shares one registered AND unit among N_REQ requesters (IDLE -> EXEC -> RESP).
// LOGIC_OP_ARB_FIXED_PRIO_EN: fixed lowest-index priority, no round-robin pointer.
module logic_op_arbiter
  import logic_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned IDW   = calc_idw(N_REQ)
) (
  input logic                clk,
  input logic                rst_n,
  logic_op_arbiter_if.slave  bus_io
);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             res_vld_q, res_vld_d;
  logic [DW-1:0]    res_data_q, res_data_d;
  logic [IDW-1:0]   res_id_q, res_id_d;
  logic [DW-1:0]    a_q, a_d;
  logic [DW-1:0]    b_q, b_d;
  logic [IDW-1:0]   id_q, id_d;

  logic [N_REQ-1:0] pick_oh;
  logic [IDW-1:0]   pick_idx;
  logic [DW-1:0]    a_sel, b_sel;

`ifndef LOGIC_OP_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]   ptr_q, ptr_d;
`endif

  rr_pick #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_rr_pick (
`ifndef LOGIC_OP_ARB_FIXED_PRIO_EN
    .ptr_i (ptr_q),
`endif
    .req_i (bus_io.req),
    .gnt_o (pick_oh),
    .idx_o (pick_idx)
  );

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_oh[i]) begin
        a_sel = bus_io.a_in[i*DW +: DW];
        b_sel = bus_io.b_in[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = '0;
    res_vld_d  = 1'b0;
    res_data_d = res_data_q;
    res_id_d   = res_id_q;
    a_d        = a_q;
    b_d        = b_q;
    id_d       = id_q;
`ifndef LOGIC_OP_ARB_FIXED_PRIO_EN
    ptr_d      = ptr_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (|bus_io.req) begin
          gnt_d   = pick_oh;
          a_d     = a_sel;
          b_d     = b_sel;
          id_d    = pick_idx;
          state_d = StExec;
        end
      end
      StExec: begin
        res_data_d = a_q & b_q;
        res_id_d   = id_q;
        res_vld_d  = 1'b1;
        state_d    = StResp;
      end
      StResp: begin
`ifndef LOGIC_OP_ARB_FIXED_PRIO_EN
        // Next search starts just past the requester that was served.
        ptr_d   = (id_q == IDW'(N_REQ - 1)) ? '0 : id_q + 1'b1;
`endif
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      res_vld_q  <= 1'b0;
      res_data_q <= '0;
      res_id_q   <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      res_vld_q  <= res_vld_d;
      res_data_q <= res_data_d;
      res_id_q   <= res_id_d;
      a_q        <= a_d;
      b_q        <= b_d;
      id_q       <= id_d;
    end
  end

`ifndef LOGIC_OP_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign bus_io.gnt      = gnt_q;
  assign bus_io.res_vld  = res_vld_q;
  assign bus_io.res_data = res_data_q;
  assign bus_io.res_id   = res_id_q;
  assign bus_io.busy     = (state_q != StIdle);

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed scoreboard bench for logic_op_arbiter; expected results are queued at grant stimulus.
module tb_logic_op_arbiter;
  import logic_arb_pkg::*;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned IDW   = 2;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic_op_arbiter_if #(.N_REQ(N_REQ), .DW(DW), .IDW(IDW)) bus ();

  logic_op_arbiter #(
    .N_REQ (N_REQ),
    .DW    (DW),
    .IDW   (IDW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  logic [DW-1:0] op_a [N_REQ];
  logic [DW-1:0] op_b [N_REQ];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int w);
    exp_t e;
    e.id   = IDW'(w);
    e.data = op_a[w] & op_b[w];
    sb.push_back(e);
  endtask

  // One clock; then sample at the falling edge and retire any result against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (bus.res_vld === 1'b1) begin
      check("gnt_vld_excl", 32'(bus.gnt), 32'h0);
      if (sb.size() == 0) begin
        check("res_vld_unexpected", 32'(bus.res_vld), 32'h0);
      end else begin
        e = sb.pop_front();
        check("res_id", 32'(bus.res_id), 32'(e.id));
        check("res_data", 32'(bus.res_data), 32'(e.data));
      end
    end
  endtask

  // Request already applied: grant expected at the next edge, result one edge later.
  task automatic serve(input int w, input logic [N_REQ-1:0] req_after);
    push_exp(w);
    tick();
    check("gnt", 32'(bus.gnt), 32'(1) << w);
    check("busy_exec", 32'(bus.busy), 32'h1);
    bus.req = req_after;
    tick();
    check("res_vld", 32'(bus.res_vld), 32'h1);
    tick();
  endtask

  initial begin
    op_a = '{8'h5A, 8'hC3, 8'hF0, 8'h99};
    op_b = '{8'hFF, 8'h6E, 8'h3C, 8'hA7};
    bus.req = '0;
    for (int i = 0; i < N_REQ; i++) begin
      bus.a_in[i*DW +: DW] = op_a[i];
      bus.b_in[i*DW +: DW] = op_b[i];
    end

    // Reset state
    #2;
    check("rst_gnt", 32'(bus.gnt), 32'h0);
    check("rst_vld", 32'(bus.res_vld), 32'h0);
    check("rst_data", 32'(bus.res_data), 32'h0);
    check("rst_id", 32'(bus.res_id), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("idle_gnt", 32'(bus.gnt), 32'h0);
    check("idle_busy", 32'(bus.busy), 32'h0);

    // Single request from requester 2
    bus.req = 4'b0100;
    serve(2, 4'b0000);
    check("resp_vld_low", 32'(bus.res_vld), 32'h0);
    check("idle_after_busy", 32'(bus.busy), 32'h0);
    check("data_hold", 32'(bus.res_data), 32'h30);

`ifndef LOGIC_OP_ARB_FIXED_PRIO_EN
    // Wrap: serve 3 (pointer returns to 0), then 1001 gives 0 then 3
    bus.req = 4'b1000;
    serve(3, 4'b1001);
    serve(0, 4'b1001);
    serve(3, 4'b0000);

    // Saturation: all four requesting, served in rotation
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      serve(k % 4, 4'b1111);
    end
    bus.req = '0;
    tick();
`else
    // Fixed priority: requester 1 always beats requester 3
    bus.req = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      serve(1, 4'b1010);
    end
    bus.req = '0;
    tick();
`endif

    // Reset during EXEC drops the transaction and clears the pointer
    bus.req = 4'b0100;
    tick();
    check("abort_gnt", 32'(bus.gnt), 32'h4);
    rst_n = 1'b0;
    #1;
    check("abort_gnt_clr", 32'(bus.gnt), 32'h0);
    check("abort_vld", 32'(bus.res_vld), 32'h0);
    check("abort_busy", 32'(bus.busy), 32'h0);
    check("abort_data", 32'(bus.res_data), 32'h0);
    check("abort_id", 32'(bus.res_id), 32'h0);
    bus.req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.req = 4'b1001;
    serve(0, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      tick();
    end

    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
